// File: rtl/ram_uart_tx_if.sv
// Bundle between the frame-buffer readback engine and its surroundings:
// start/status handshake, synchronous RAM read port and the serial line.
interface ram_uart_tx_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              uart_tx;
    logic              busy;
    logic              done;

    modport master (
        output start, rd_data,
        input  rd_en, rd_addr, uart_tx, busy, done
    );

    modport slave (
        input  start, rd_data,
        output rd_en, rd_addr, uart_tx, busy, done
    );
endinterface

// File: rtl/ram_uart_tx.sv
// Frame-buffer readback: reads NUM_WORDS RGB565 pixels from a latency-1 RAM
// and sends each as two 8N1 bytes (high byte first) on uart_tx.
module ram_uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int NUM_WORDS = 32768,
    parameter int ADDR_W    = 15
) (
    input  logic           Clk,
    input  logic           Reset_n,
    ram_uart_tx_if.slave   bus
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = $clog2(BAUD_DIV + 1);

    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]   BAUD_TAIL = BW'(BAUD_DIV);
    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        TX_HI,
        TX_LO
    } state_t;

    state_t            state_reg;
    logic [BW-1:0]     baud_cnt_reg;
    logic [3:0]        bit_cnt_reg;
    logic [ADDR_W:0]   word_idx_reg;
    logic [7:0]        lo_byte_reg;
    logic [9:0]        shifter_reg;
    logic              uart_tx_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr_reg;

    logic              last_word;
    logic [BW-1:0]     baud_end;
    logic [ADDR_W:0]   word_idx_next;

    assign last_word     = (word_idx_reg == LAST_IDX);
    assign word_idx_next = word_idx_reg + (ADDR_W+1)'(1);

    // uart_tx is registered one cycle behind the bit counters, so the final
    // stop bit of the dump runs one extra cycle to let done coincide with
    // the stop bit actually finishing on the line.
    assign baud_end = (state_reg == TX_LO && bit_cnt_reg == 4'd9 && last_word)
                      ? BAUD_TAIL : BAUD_LAST;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            word_idx_reg <= '0;
            lo_byte_reg  <= '0;
            shifter_reg  <= '1;
            uart_tx_reg  <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
        end else begin
            done_reg  <= 1'b0;
            rd_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    uart_tx_reg <= 1'b1;
                    // done still high means the previous dump ended this cycle
                    if (bus.start && !done_reg) begin
                        state_reg    <= READ;
                        busy_reg     <= 1'b1;
                        word_idx_reg <= '0;
                        rd_addr_reg  <= '0;
                        rd_en_reg    <= 1'b1;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                    end
                end
                READ: begin
                    uart_tx_reg <= 1'b1;
                    state_reg   <= LOAD;
                end
                LOAD: begin
                    uart_tx_reg <= 1'b1;
                    lo_byte_reg <= bus.rd_data[7:0];
                    shifter_reg <= {1'b1, bus.rd_data[15:8], 1'b0};
                    state_reg   <= TX_HI;
                end
                TX_HI, TX_LO: begin
                    uart_tx_reg <= shifter_reg[0];
                    if (baud_cnt_reg == baud_end) begin
                        baud_cnt_reg <= '0;
                        shifter_reg  <= {1'b1, shifter_reg[9:1]};
                        if (bit_cnt_reg == 4'd9) begin
                            bit_cnt_reg <= '0;
                            if (state_reg == TX_HI) begin
                                shifter_reg <= {1'b1, lo_byte_reg, 1'b0};
                                state_reg   <= TX_LO;
                            end else if (last_word) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                word_idx_reg <= word_idx_next;
                                rd_addr_reg  <= word_idx_next[ADDR_W-1:0];
                                rd_en_reg    <= 1'b1;
                                state_reg    <= READ;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BW'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    uart_tx_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uart_tx = uart_tx_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.rd_en   = rd_en_reg;
    assign bus.rd_addr = rd_addr_reg;
endmodule

// File: tb/tb_ram_uart_tx.sv
// Bench for ram_uart_tx: cycle-exact waveform model for a fast-baud 3-word
// instance, plus a serial decoder on a default-baud 4-word instance.
`timescale 1ns/1ps
module tb_ram_uart_tx;
    localparam int CLK_HZ = 50_000_000;
    localparam int A_BAUD = 5_000_000;
    localparam int A_N    = 3;
    localparam int A_AW   = 4;
    localparam int A_D    = CLK_HZ / A_BAUD;
    localparam int A_P    = 20 * A_D + 2;
    localparam int B_BAUD = 115200;
    localparam int B_N    = 4;
    localparam int B_AW   = 15;
    localparam int B_D    = CLK_HZ / B_BAUD;
    localparam int B_P    = 20 * B_D + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_uart_tx_if #(.ADDR_W(A_AW)) bus_a ();
    ram_uart_tx_if #(.ADDR_W(B_AW)) bus_b ();

    ram_uart_tx #(.CLK_FREQ(CLK_HZ), .BAUD(A_BAUD), .NUM_WORDS(A_N), .ADDR_W(A_AW))
        dut_a (.Clk(clk), .Reset_n(rst_n), .bus(bus_a));
    ram_uart_tx #(.CLK_FREQ(CLK_HZ), .BAUD(B_BAUD), .NUM_WORDS(B_N), .ADDR_W(B_AW))
        dut_b (.Clk(clk), .Reset_n(rst_n), .bus(bus_b));

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [B_N];

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_a.rd_data = 16'h0;
        bus_b.rd_data = 16'h0;
    end

    // Synchronous RAMs, read latency 1
    always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
    always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr[1:0]];

    // Reference model for instance A; t = cycles after the start edge.
    function automatic logic exp_tx(int t);
        int k, off, bp, b;
        logic [15:0] px;
        logic [7:0] by;
        k = t / A_P;
        off = t - k * A_P;
        if (k >= A_N || off < 3 || off >= 3 + 20 * A_D) return 1'b1;
        bp = (off - 3) / A_D;
        px = mem_a[k];
        by = (bp < 10) ? px[15:8] : px[7:0];
        b = bp % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    function automatic logic exp_busy(int t);
        return t <= A_N * A_P;
    endfunction

    function automatic logic exp_done(int t);
        return t == A_N * A_P + 1;
    endfunction

    function automatic logic exp_rd_en(int t);
        return (t % A_P == 0) && (t / A_P < A_N);
    endfunction

    function automatic logic [15:0] exp_rd_addr(int t);
        return (t / A_P < A_N) ? 16'(t / A_P) : 16'(A_N - 1);
    endfunction

    task automatic fill_a_random();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'($urandom);
    endtask

    task automatic launch_a();
        @(negedge clk);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
    endtask

    // Compares every output of instance A on every cycle of one dump.
    task automatic check_dump(input string name, input bit ignore_starts, input bit restart);
        int t_end;
        int bad_t [5];
        logic [15:0] obs [5];
        logic [15:0] ref_v [5];
        logic [15:0] got_v [5];
        logic [15:0] want_v [5];
        string sig [5];
        sig = '{"uart_tx", "busy", "done", "rd_en", "rd_addr"};
        t_end = restart ? A_N * A_P + 2 : A_N * A_P + 6;
        for (int i = 0; i < 5; i++) begin
            bad_t[i] = -1;
            got_v[i] = '0;
            want_v[i] = '0;
        end
        for (int t = 0; t <= t_end; t++) begin
            obs[0] = 16'(bus_a.uart_tx);
            obs[1] = 16'(bus_a.busy);
            obs[2] = 16'(bus_a.done);
            obs[3] = 16'(bus_a.rd_en);
            obs[4] = 16'(bus_a.rd_addr);
            ref_v[0] = 16'(exp_tx(t));
            ref_v[1] = 16'(exp_busy(t));
            ref_v[2] = 16'(exp_done(t));
            ref_v[3] = 16'(exp_rd_en(t));
            ref_v[4] = exp_rd_addr(t);
            for (int i = 0; i < 5; i++) begin
                if (obs[i] !== ref_v[i] && bad_t[i] < 0) begin
                    bad_t[i] = t;
                    got_v[i] = obs[i];
                    want_v[i] = ref_v[i];
                end
            end
            if (ignore_starts && (t == A_P + 5 || t == A_N * A_P + 1)) bus_a.start = 1'b1;
            if (restart && t == t_end) bus_a.start = 1'b1;
            @(posedge clk);
            #1 bus_a.start = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bad_t[i] >= 0) begin
                bad++;
                $display("FAIL %s %s at cycle %0d: got %0h expected %0h",
                         name, sig[i], bad_t[i], got_v[i], want_v[i]);
            end else begin
                $display("ok   %s %s over %0d cycles", name, sig[i], t_end + 1);
            end
        end
    endtask

    task automatic test_reset();
        logic [9:0] v;
        int bad_c;
        rst_n = 1'b0;
        bad_c = -1;
        v = '0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if ({bus_a.uart_tx, bus_a.busy, bus_a.rd_en, bus_a.done, |bus_a.rd_addr,
                 bus_b.uart_tx, bus_b.busy, bus_b.rd_en, bus_b.done, |bus_b.rd_addr}
                !== 10'b10000_10000 && bad_c < 0) begin
                bad_c = cyc;
                v = {bus_a.uart_tx, bus_a.busy, bus_a.rd_en, bus_a.done, |bus_a.rd_addr,
                     bus_b.uart_tx, bus_b.busy, bus_b.rd_en, bus_b.done, |bus_b.rd_addr};
            end
            bus_a.start = ~bus_a.start;
            bus_b.start = bus_a.start;
        end
        total++;
        if (bad_c >= 0) begin
            bad++;
            $display("FAIL reset_hold outputs got %b expected %b", v, 10'b10000_10000);
        end else $display("ok   reset_hold");
        #10;
        rst_n = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bad_c = -1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if ({bus_a.uart_tx, bus_a.busy, bus_a.rd_en, bus_a.done,
                 bus_b.uart_tx, bus_b.busy, bus_b.rd_en, bus_b.done} !== 8'b1000_1000
                && bad_c < 0) begin
                bad_c = cyc;
                v = {2'b0, bus_a.uart_tx, bus_a.busy, bus_a.rd_en, bus_a.done,
                     bus_b.uart_tx, bus_b.busy, bus_b.rd_en, bus_b.done};
            end
        end
        total++;
        if (bad_c >= 0) begin
            bad++;
            $display("FAIL idle_after_release got %b expected %b", v[7:0], 8'b1000_1000);
        end else $display("ok   idle_after_release");
    endtask

    task automatic test_fixed_pixels();
        mem_a[0] = 16'h0001;
        mem_a[1] = 16'hF800;
        mem_a[2] = 16'hFFFF;
        launch_a();
        check_dump("fixed", 1'b0, 1'b0);
    endtask

    task automatic test_random_pixels();
        for (int r = 0; r < 3; r++) begin
            fill_a_random();
            if (r == 0) mem_a[0] = 16'hA55A;
            launch_a();
            check_dump($sformatf("random%0d", r), 1'b0, 1'b0);
        end
    endtask

    task automatic test_ignored_start();
        fill_a_random();
        launch_a();
        check_dump("ignored_start", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_a_random();
        launch_a();
        check_dump("b2b_first", 1'b0, 1'b1);
        fill_a_random();
        check_dump("b2b_second", 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int t_hit;
        logic want;
        t_hit = 3 + 13 * A_D + A_D / 2;
        fill_a_random();
        launch_a();
        repeat (t_hit) @(posedge clk);
        #1;
        want = exp_tx(t_hit);
        total++;
        if ({bus_a.busy, bus_a.uart_tx} !== {1'b1, want}) begin
            bad++;
            $display("FAIL abort_pre busy/uart_tx got %b%b expected 1%b",
                     bus_a.busy, bus_a.uart_tx, want);
        end else $display("ok   abort_pre");
        #4 rst_n = 1'b0;
        #1;
        total++;
        if ({bus_a.uart_tx, bus_a.busy, bus_a.rd_en, bus_a.done, bus_a.rd_addr} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL abort_async got %b expected %b",
                     {bus_a.uart_tx, bus_a.busy, bus_a.rd_en, bus_a.done, bus_a.rd_addr}, 8'b1000_0000);
        end else $display("ok   abort_async");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        fill_a_random();
        launch_a();
        check_dump("after_abort", 1'b0, 1'b0);
    endtask

    // Default-baud instance: a software 8N1 receiver samples mid-bit.
    task automatic test_loopback();
        int cyc0, wait_c;
        logic [7:0] rx, want;
        logic [15:0] w;
        logic sb, pb;
        for (int k = 0; k < B_N; k++) mem_b[k] = 16'($urandom);
        @(negedge clk);
        bus_b.start = 1'b1;
        @(posedge clk);
        #1 bus_b.start = 1'b0;
        cyc0 = cyc;
        for (int n = 0; n < 2 * B_N; n++) begin
            wait_c = 0;
            while (bus_b.uart_tx !== 1'b0 && wait_c < 4 * B_D) begin
                @(posedge clk);
                #1 wait_c++;
            end
            repeat (B_D / 2) @(posedge clk);
            #1 sb = bus_b.uart_tx;
            for (int b = 0; b < 8; b++) begin
                repeat (B_D) @(posedge clk);
                #1 rx[b] = bus_b.uart_tx;
            end
            repeat (B_D) @(posedge clk);
            #1 pb = bus_b.uart_tx;
            w = mem_b[n / 2];
            want = (n % 2 == 0) ? w[15:8] : w[7:0];
            total++;
            if ({pb, rx, sb} !== {1'b1, want, 1'b0}) begin
                bad++;
                $display("FAIL loop_byte%0d frame got %b expected %b", n, {pb, rx, sb}, {1'b1, want, 1'b0});
            end else $display("ok   loop_byte%0d = %02h", n, rx);
        end
        wait_c = 0;
        while (bus_b.done !== 1'b1 && wait_c < 2 * B_D) begin
            @(posedge clk);
            #1 wait_c++;
        end
        total++;
        if (cyc - cyc0 !== B_N * B_P + 1) begin
            bad++;
            $display("FAIL loop_done latency got %0d expected %0d", cyc - cyc0, B_N * B_P + 1);
        end else $display("ok   loop_done latency %0d", cyc - cyc0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fixed_pixels();
        test_random_pixels();
        test_ignored_start();
        test_back_to_back();
        test_abort();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
